// File: rtl/piso_debug_pkg.sv
// Shared types and beat-geometry helpers for the debug PISO transmitter.
// All geometry is derived from WORD_SIZE, PAR and the masking order d.
package piso_debug_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam int DEF_WORD_SIZE = 64;
    localparam int DEF_PAR       = 7;
    localparam int DEF_D         = 2;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int calc_nb1(input int ws, input int par);
        return ceil_div(ws, par);
    endfunction

    // A wide slice that covers the whole word collapses to a single beat.
    function automatic int calc_nbd(input int ws, input int par, input int d);
        int w;
        w = (d + 1) * par;
        return (w >= ws) ? 1 : ceil_div(ws, w);
    endfunction

    function automatic int calc_last(input int ws, input int w);
        return ((ws % w) == 0) ? w : (ws % w);
    endfunction

    function automatic int calc_par_last(input int ws, input int par);
        return calc_last(ws, par);
    endfunction

    function automatic int calc_pard_last(input int ws, input int par, input int d);
        return calc_last(ws, (d + 1) * par);
    endfunction

    function automatic int calc_cnt_w(input int ws, input int par);
        int n;
        n = calc_nb1(ws, par);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = calc_cnt_w(DEF_WORD_SIZE, DEF_PAR);

endpackage

// File: rtl/piso_debug_if.sv
// Load and slice-stream signals of the debug PISO transmitter.
// master = word source / slice consumer, slave = the transmitter.
interface piso_debug_if #(
    parameter int WORD_SIZE = piso_debug_pkg::DEF_WORD_SIZE,
    parameter int PAR       = piso_debug_pkg::DEF_PAR,
    parameter int d         = piso_debug_pkg::DEF_D
) ();
    localparam int SP   = PAR;
    localparam int SPD1 = (d + 1) * PAR;

    logic                 load_valid;
    logic                 load_ready;
    logic                 load_type;
    logic [WORD_SIZE-1:0] data_in;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_type;
    logic [SP-1:0]        out_1bit;
    logic [SPD1-1:0]      out_dplus1;
    logic                 out_last;

    modport master (
        output load_valid, load_type, data_in, out_ready,
        input  load_ready, out_valid, out_type, out_1bit, out_dplus1, out_last
    );

    modport slave (
        input  load_valid, load_type, data_in, out_ready,
        output load_ready, out_valid, out_type, out_1bit, out_dplus1, out_last
    );
endinterface

// File: rtl/piso_beat_ctr.sv
// Loadable down-counter of remaining beats; saturates at zero.
// zero_nxt_o reflects the value the counter takes at the coming edge.
module piso_beat_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_nxt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign zero_nxt_o = (cnt_d == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/piso_debug.sv
// Debug PISO: sends a word LSB-first as narrow or wide slices, first slice the cycle after load.
// Outputs hold under out_ready low; load_ready is combinational from out_ready on the final beat.
module piso_debug
    import piso_debug_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int PAR       = DEF_PAR,
    parameter int d         = DEF_D
) (
    input logic        clk,
    input logic        reset_n,
    piso_debug_if.slave dbg
);
    localparam int SP        = PAR;
    localparam int SPD1      = (d + 1) * PAR;
    localparam int SP_LAST   = calc_par_last(WORD_SIZE, PAR);
    localparam int SPD1_LAST = calc_pard_last(WORD_SIZE, PAR, d);
    localparam int NB1       = calc_nb1(WORD_SIZE, PAR);
    localparam int NBD       = calc_nbd(WORD_SIZE, PAR, d);
    localparam int CW        = calc_cnt_w(WORD_SIZE, PAR);

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] sreg_q, sreg_d;
    logic                 type_q, type_d;
    logic [SP-1:0]        out_1bit_q, out_1bit_d;
    logic [SPD1-1:0]      out_dplus1_q, out_dplus1_d;
    logic                 last_q, last_d;

    logic                 beat_fire, load_fire, ctr_zero_nxt;
    logic [SPD1-1:0]      wide_raw;
    logic [SP-1:0]        nmask;
    logic [SPD1-1:0]      wmask;

    assign dbg.out_valid  = (state_q == SEND);
    assign beat_fire      = (state_q == SEND) && dbg.out_ready;
    assign dbg.load_ready = (state_q == IDLE) || (beat_fire && last_q);
    assign load_fire      = dbg.load_valid && dbg.load_ready;

    piso_beat_ctr #(.W(CW)) u_ctr (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (load_fire),
        .load_val_i (dbg.load_type ? CW'(NB1 - 1) : CW'(NBD - 1)),
        .dec_i      (beat_fire),
        .zero_nxt_o (ctr_zero_nxt)
    );

    // Final-beat masks: only the residual bits of the word may be nonzero.
    for (genvar i = 0; i < SP; i++) begin : g_nmask
        assign nmask[i] = (i < SP_LAST);
    end
    for (genvar i = 0; i < SPD1; i++) begin : g_wmask
        assign wmask[i] = (i < SPD1_LAST);
    end

    if (SPD1 <= WORD_SIZE) begin : g_wide_fit
        assign wide_raw = sreg_d[SPD1-1:0];
    end else begin : g_wide_ext
        assign wide_raw = {{(SPD1 - WORD_SIZE){1'b0}}, sreg_d};
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        type_d  = type_q;
        if (load_fire) begin
            state_d = SEND;
            sreg_d  = dbg.data_in;
            type_d  = dbg.load_type;
        end else if (beat_fire) begin
            sreg_d = type_q ? (sreg_q >> SP) : (sreg_q >> SPD1);
            if (last_q) begin
                state_d = IDLE;
            end
        end
    end

    // Slice registers are computed from the next shift-register value so they are pure flops.
    always_comb begin
        last_d       = (state_d == SEND) && ctr_zero_nxt;
        out_1bit_d   = sreg_d[SP-1:0] & (last_d ? nmask : {SP{1'b1}});
        out_dplus1_d = wide_raw & (last_d ? wmask : {SPD1{1'b1}});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sreg_q       <= '0;
            type_q       <= 1'b0;
            out_1bit_q   <= '0;
            out_dplus1_q <= '0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            type_q       <= type_d;
            out_1bit_q   <= out_1bit_d;
            out_dplus1_q <= out_dplus1_d;
            last_q       <= last_d;
        end
    end

    assign dbg.out_type   = type_q;
    assign dbg.out_1bit   = out_1bit_q;
    assign dbg.out_dplus1 = out_dplus1_q;
    assign dbg.out_last   = last_q;
endmodule
